// File: rtl/window3x3_gen.sv
// -----------------------------------------------------------------------------
// window3x3_gen
//
// Purpose:
//   Producer side of the 3x3 neighbourhood interface. It takes a raster-order
//   pixel stream and builds a registered 3x3 window (win_o0..win_o8) for each
//   interior pixel. Two line buffers hold the previous two lines, and a 3x3
//   shift array holds the window.
//
// Ports:
//   clk           in   1      clock; all logic changes on the rising edge
//   rst_n         in   1      asynchronous reset, active low
//   pix_i         in   PIX_W  input pixel {R,G,B}
//   pix_valid_i   in   1      pix_i valid this cycle (no backpressure)
//   sof_i         in   1      marks pix_i as pixel (0,0); only sampled with pix_valid_i
//   win_o0..8     out  PIX_W  window, row-major; o0=(x-2,y-2), o4=centre, o8=(x,y)
//   win_valid_o   out  1      one-cycle pulse when a new window is presented
//   frame_done_o  out  1      pulses with the last window of a frame
//   win_x_o       out  XW     centre x of the window (only with WIN3X3_COORD_EN)
//   win_y_o       out  YW     centre y of the window (only with WIN3X3_COORD_EN)
//
// Optional feature:
//   Define WIN3X3_COORD_EN to add the win_x_o/win_y_o centre-coordinate outputs.
//   These outputs are registered together with the window.
// -----------------------------------------------------------------------------
module window3x3_gen #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int PIX_W = 24
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [PIX_W-1:0]           pix_i,
    input  logic                       pix_valid_i,
    input  logic                       sof_i,
    output logic [PIX_W-1:0]           win_o0,
    output logic [PIX_W-1:0]           win_o1,
    output logic [PIX_W-1:0]           win_o2,
    output logic [PIX_W-1:0]           win_o3,
    output logic [PIX_W-1:0]           win_o4,
    output logic [PIX_W-1:0]           win_o5,
    output logic [PIX_W-1:0]           win_o6,
    output logic [PIX_W-1:0]           win_o7,
    output logic [PIX_W-1:0]           win_o8,
    output logic                       win_valid_o,
`ifdef WIN3X3_COORD_EN
    output logic [$clog2(IMG_W)-1:0]   win_x_o,
    output logic [$clog2(IMG_H)-1:0]   win_y_o,
`endif
    output logic                       frame_done_o
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    logic [XW-1:0]    x_reg, x_cur, x_next;
    logic [YW-1:0]    y_reg, y_cur, y_next;
    logic             emit;
    logic             win_valid_reg;
    logic             frame_done_reg;

    // Line buffers: lb0 holds line y-1 and lb1 holds line y-2 at column x.
    // The read is asynchronous so that the column that is read can be shifted
    // in on the same edge that overwrites it (read-before-write).
    logic [PIX_W-1:0] lb0_mem [IMG_W];
    logic [PIX_W-1:0] lb1_mem [IMG_W];
    logic [PIX_W-1:0] lb0_rd, lb1_rd;

    logic [PIX_W-1:0] col      [3];
    logic [PIX_W-1:0] win_reg  [9];
    logic [PIX_W-1:0] win_next [9];

    // sof forces the current pixel to (0,0). Every downstream decision uses
    // x_cur/y_cur, so a mid-frame sof restarts the frame cleanly.
    always_comb begin
        x_cur = sof_i ? '0 : x_reg;
        y_cur = sof_i ? '0 : y_reg;
        if (x_cur == X_LAST) begin
            x_next = '0;
            y_next = (y_cur == Y_LAST) ? '0 : y_cur + YW'(1);
        end else begin
            x_next = x_cur + XW'(1);
            y_next = y_cur;
        end
        // The x>=2 gate keeps columns from the previous line out of the window.
        // The y>=2 gate keeps stale line-buffer contents out of the window.
        emit = (x_cur >= XW'(2)) && (y_cur >= YW'(2));
    end

    assign lb0_rd = lb0_mem[x_cur];
    assign lb1_rd = lb1_mem[x_cur];

    // New right-hand column, from the oldest row to the newest row.
    assign col[0] = lb1_rd;
    assign col[1] = lb0_rd;
    assign col[2] = pix_i;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_row
            assign win_next[gi*3 + 0] = win_reg[gi*3 + 1];
            assign win_next[gi*3 + 1] = win_reg[gi*3 + 2];
            assign win_next[gi*3 + 2] = col[gi];
        end
    endgenerate

    // The line buffers are not reset, so that they can map onto RAM.
    always_ff @(posedge clk) begin
        if (pix_valid_i) begin
            lb0_mem[x_cur] <= pix_i;
            lb1_mem[x_cur] <= lb0_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg          <= '0;
            y_reg          <= '0;
            win_valid_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win_reg[i] <= '0;
            end
        end else begin
            win_valid_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
            if (pix_valid_i) begin
                x_reg          <= x_next;
                y_reg          <= y_next;
                win_valid_reg  <= emit;
                frame_done_reg <= emit && (x_cur == X_LAST) && (y_cur == Y_LAST);
                for (int i = 0; i < 9; i++) begin
                    win_reg[i] <= win_next[i];
                end
            end
        end
    end

`ifdef WIN3X3_COORD_EN
    logic [XW-1:0] win_x_reg;
    logic [YW-1:0] win_y_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_x_reg <= '0;
            win_y_reg <= '0;
        end else if (pix_valid_i && emit) begin
            win_x_reg <= x_cur - XW'(1);
            win_y_reg <= y_cur - YW'(1);
        end
    end

    assign win_x_o = win_x_reg;
    assign win_y_o = win_y_reg;
`endif

    assign win_o0       = win_reg[0];
    assign win_o1       = win_reg[1];
    assign win_o2       = win_reg[2];
    assign win_o3       = win_reg[3];
    assign win_o4       = win_reg[4];
    assign win_o5       = win_reg[5];
    assign win_o6       = win_reg[6];
    assign win_o7       = win_reg[7];
    assign win_o8       = win_reg[8];
    assign win_valid_o  = win_valid_reg;
    assign frame_done_o = frame_done_reg;

endmodule
